pc_fetch_sequencer: RTL and testbench

//   Multi-cycle fetch controller for the program-counter block.
//   - Drives the PC next-value select PS and the PC's synchronous clear.
//   - Handshakes each fetch with instruction memory.
//   - Waits for the datapath to finish the instruction, then applies one PC update:

---
 rtl/pc_fetch_sequencer.sv | 117 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch controller for the program-counter block: sequences PC clear,
// instruction-memory handshake, execution wait and a single PC select per instruction.
module pc_fetch_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             instr_done,
    input  logic             redirect,
    input  logic             redirect_rel,
    input  logic             halt_req,
    output logic [1:0]       PS,
    output logic             pc_clear,
    output logic             fetch_req,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_FETCH  = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALTED = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t           state_reg, state_next;
    logic [WD_W-1:0]  wdog_reg, wdog_next;
    logic [1:0]       sel_reg, sel_next;
    logic [CNT_W-1:0] count_reg, count_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            wdog_reg  <= '0;
            sel_reg   <= 2'b01;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            wdog_reg  <= wdog_next;
            sel_reg   <= sel_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wdog_next  = wdog_reg;
        sel_next   = sel_reg;
        count_next = count_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_INIT;
            end
            S_INIT: begin
                state_next = S_FETCH;
                wdog_next  = '0;
            end
            S_FETCH: begin
                // A stalled cycle neither handshakes nor counts toward the watchdog.
                if (!stall) begin
                    if (imem_ready) begin
                        state_next = S_EXEC;
                    end else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
                        state_next = S_ERROR;
                    end else begin
                        wdog_next = wdog_reg + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (instr_done) begin
                    sel_next   = redirect ? (redirect_rel ? 2'b11 : 2'b10) : 2'b01;
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (!stall) begin
                    count_next = count_reg + 1'b1;
                    wdog_next  = '0;
                    state_next = halt_req ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: state_next = S_HALTED;
            S_ERROR:  state_next = S_ERROR;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        PS        = 2'b00;
        pc_clear  = 1'b0;
        fetch_req = 1'b0;
        halted    = 1'b0;
        error     = 1'b0;
        case (state_reg)
            S_INIT:   pc_clear  = 1'b1;
            S_FETCH:  fetch_req = !stall;
            S_UPDATE: PS        = stall ? 2'b00 : sel_reg;
            S_HALTED: halted    = 1'b1;
            S_ERROR:  error     = 1'b1;
            default:  PS        = 2'b00;
        endcase
    end

    assign instr_count = count_reg;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: stimulus queues expected events, a monitor
// pops and compares them whenever the DUT emits pc_clear, a PS pulse, error or halted.
module tb_pc_fetch_sequencer;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    localparam int EV_CLEAR = 0;
    localparam int EV_PS    = 1;
    localparam int EV_ERROR = 2;
    localparam int EV_HALT  = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stall = 1'b0;
    logic             imem_ready = 1'b0;
    logic             instr_done = 1'b0;
    logic             redirect = 1'b0;
    logic             redirect_rel = 1'b0;
    logic             halt_req = 1'b0;
    logic [1:0]       PS;
    logic             pc_clear;
    logic             fetch_req;
    logic             halted;
    logic             error;
    logic [CNT_W-1:0] instr_count;

    pc_fetch_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .instr_done  (instr_done),
        .redirect    (redirect),
        .redirect_rel(redirect_rel),
        .halt_req    (halt_req),
        .PS          (PS),
        .pc_clear    (pc_clear),
        .fetch_req   (fetch_req),
        .halted      (halted),
        .error       (error),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int               kind;
        logic [1:0]       ps;
        logic [CNT_W-1:0] cnt;
    } ev_t;

    ev_t              exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input int kind, input logic [1:0] ps, input logic [CNT_W-1:0] cnt);
        ev_t e;
        e.kind = kind;
        e.ps   = ps;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor
    logic             err_q = 1'b0;
    logic             halt_q = 1'b0;
    logic             cnt_pend = 1'b0;
    logic [CNT_W-1:0] cnt_exp_m = '0;

    task automatic observe(input int kind, input logic [1:0] ps);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d PS %0b expected none at %0t", kind, ps, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == EV_PS) begin
                check("ps_value", {30'd0, ps}, {30'd0, e.ps});
                cnt_pend  = 1'b1;
                cnt_exp_m = e.cnt;
            end
            $display("txn kind=%0d PS=%0b count=%0d t=%0t", kind, ps, instr_count, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                err_q    = 1'b0;
                halt_q   = 1'b0;
                cnt_pend = 1'b0;
            end else begin
                if (cnt_pend) begin
                    check("count_after_update", {28'd0, instr_count}, {28'd0, cnt_exp_m});
                    cnt_pend = 1'b0;
                end
                if (pc_clear)         observe(EV_CLEAR, 2'b00);
                if (PS != 2'b00)      observe(EV_PS, PS);
                if (error && !err_q)  observe(EV_ERROR, 2'b00);
                if (halted && !halt_q) observe(EV_HALT, 2'b00);
                err_q  = error;
                halt_q = halted;
            end
        end
    end

    // Stimulus helpers: each starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0; stall = 1'b0; imem_ready = 1'b0; instr_done = 1'b0;
        redirect = 1'b0; redirect_rel = 1'b0; halt_req = 1'b0;
        exp_cnt = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic do_start();
        push(EV_CLEAR, 2'b00, '0);
        start = 1'b1;
        @(negedge clock);
        check("idle_fetch_req", {31'd0, fetch_req}, 32'd0);
        tick();
        start = 1'b0;
        @(negedge clock);
        check("init_pc_clear", {31'd0, pc_clear}, 32'd1);
        check("init_fetch_req", {31'd0, fetch_req}, 32'd0);
        tick();
    endtask

    task automatic do_fetch(input int waits, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            imem_ready = 1'b1;
            @(negedge clock);
            check("fetch_stalled_req", {31'd0, fetch_req}, 32'd0);
            tick();
        end
        stall = 1'b0;
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            @(negedge clock);
            check("fetch_req_wait", {31'd0, fetch_req}, 32'd1);
            tick();
        end
        imem_ready = 1'b1;
        @(negedge clock);
        check("fetch_req_hs", {31'd0, fetch_req}, 32'd1);
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic do_exec(input int waits, input logic rd, input logic rel);
        logic [1:0] ps_exp;
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b1;
            @(negedge clock);
            check("exec_fetch_req", {31'd0, fetch_req}, 32'd0);
            tick();
        end
        imem_ready = 1'b0;
        instr_done = 1'b1;
        redirect = rd;
        redirect_rel = rel;
        ps_exp = rd ? (rel ? 2'b11 : 2'b10) : 2'b01;
        exp_cnt = exp_cnt + 1'b1;
        push(EV_PS, ps_exp, exp_cnt);
        tick();
        instr_done = 1'b0;
        redirect = 1'b0;
        redirect_rel = 1'b0;
    endtask

    task automatic do_update(input int stalls, input logic halt);
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            @(negedge clock);
            check("update_stall_ps", {30'd0, PS}, 32'd0);
            tick();
        end
        stall = 1'b0;
        halt_req = halt;
        if (halt) push(EV_HALT, 2'b00, '0);
        tick();
        halt_req = 1'b0;
    endtask

    task automatic instr(input int fw, input int fs, input int ew, input logic rd,
                         input logic rel, input int us, input logic halt);
        do_fetch(fw, fs);
        do_exec(ew, rd, rel);
        do_update(us, halt);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        @(negedge clock);
        check("rst_ps", {30'd0, PS}, 32'd0);
        check("rst_pc_clear", {31'd0, pc_clear}, 32'd0);
        check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_count", {28'd0, instr_count}, 32'd0);
        tick();

        // Sequential PC+4 with a three-cycle memory wait
        do_start();
        instr(3, 0, 1, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clock);
        check("t1_count", {28'd0, instr_count}, 32'd1);
        tick();

        // Absolute then PC-relative redirect
        instr(0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
        instr(0, 0, 2, 1'b1, 1'b1, 0, 1'b0);
        @(negedge clock);
        check("t2_count", {28'd0, instr_count}, 32'd3);
        tick();

        // Stall in FETCH (with imem_ready) and three stalled UPDATE cycles
        instr(1, 2, 0, 1'b0, 1'b0, 3, 1'b0);

        // Halt after the update
        instr(0, 0, 0, 1'b1, 1'b1, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b1; start = 1'b1; instr_done = 1'b1;
            @(negedge clock);
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_fetch_req", {31'd0, fetch_req}, 32'd0);
            check("halt_ps", {30'd0, PS}, 32'd0);
            tick();
        end
        imem_ready = 1'b0; start = 1'b0; instr_done = 1'b0;
        @(negedge clock);
        check("t4_count", {28'd0, instr_count}, 32'd5);
        tick();

        // Watchdog expiry with memory never ready
        do_reset();
        @(negedge clock);
        check("rst2_count", {28'd0, instr_count}, 32'd0);
        tick();
        do_start();
        push(EV_ERROR, 2'b00, '0);
        for (int i = 0; i < TIMEOUT; i++) begin
            imem_ready = 1'b0;
            @(negedge clock);
            check("wd_fetch_req", {31'd0, fetch_req}, 32'd1);
            check("wd_error_low", {31'd0, error}, 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'b1;
            stall = i[0];
            @(negedge clock);
            check("err_flag", {31'd0, error}, 32'd1);
            check("err_ps", {30'd0, PS}, 32'd0);
            check("err_fetch_req", {31'd0, fetch_req}, 32'd0);
            tick();
        end
        stall = 1'b0; imem_ready = 1'b0;

        // Asynchronous reset in EXEC abandons the instruction
        do_reset();
        do_start();
        instr(0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        do_fetch(0, 0);
        #2;
        reset = 1'b0;
        exp_cnt = '0;
        #1;
        check("arst_ps", {30'd0, PS}, 32'd0);
        check("arst_pc_clear", {31'd0, pc_clear}, 32'd0);
        check("arst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("arst_halted", {31'd0, halted}, 32'd0);
        check("arst_error", {31'd0, error}, 32'd0);
        check("arst_count", {28'd0, instr_count}, 32'd0);
        instr_done = 1'b1;
        tick();
        tick();
        instr_done = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("arst_idle_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("arst_idle_ps", {30'd0, PS}, 32'd0);
        tick();

        // Counter wrap: 17 instructions on a 4-bit counter
        do_start();
        for (int i = 0; i < 17; i++) instr(0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clock);
        check("wrap_count", {28'd0, instr_count}, 32'd1);
        tick();
        tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
